// File: rtl/io_pinmux.sv
// rtl/io_pinmux.sv - Wishbone-programmed IO pad function multiplexer
//
// Purpose: per-pad function select (GPIO plus NUM_FUNCS-1 peripheral
// alternates) written over Wishbone, with a sticky LOCK bit, combinational
// output muxing and a synchronised (optionally debounced) input path.
//
// Optional feature: define PINMUX_DEBOUNCE_EN to insert a per-pad debounce
// stage (DEB_CYCLES stability window) between the synchroniser and func_in.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_*                   Wishbone slave (stb/cyc/we/sel/adr/dat, ack/dat_o)
//   io_in                   raw pad inputs
//   io_out, io_oeb          pad drive and active-low pad output enable
//   func_out, func_oe       per-function drive/enable, bit f*NUM_PADS+p
//   func_in                 conditioned pad input per function, same packing
module io_pinmux #(
    parameter int NUM_PADS    = 38,
    parameter int NUM_FUNCS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_PADS-1:0]           io_in,
    output logic [NUM_PADS-1:0]           io_out,
    output logic [NUM_PADS-1:0]           io_oeb,
    input  logic [NUM_FUNCS*NUM_PADS-1:0] func_out,
    input  logic [NUM_FUNCS*NUM_PADS-1:0] func_oe,
    output logic [NUM_FUNCS*NUM_PADS-1:0] func_in
);

    localparam int FW = $clog2(NUM_FUNCS);
    localparam logic [6:0] LOCK_IDX = 7'd64;

    logic [FW-1:0]       sel_q [NUM_PADS];
    logic [FW-1:0]       eff   [NUM_PADS];
    logic                lock_q;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic                pend_q;
    logic [6:0]          pend_idx_q;
    logic [FW-1:0]       pend_val_q;
    logic                pend_bit0_q;
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] cond;
    logic                req;
    logic [6:0]          idx;
    logic [31:0]         rd_data;
    logic                unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:9], wbs_adr_i[1:0], wbs_dat_i[31:FW], wbs_sel_i[3:1]};

    // A new request is only taken while ack is low, which also keeps acks
    // from ever landing back to back.
    assign req = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign idx = wbs_adr_i[8:2];

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    always_comb begin
        rd_data = 32'd0;
        if (idx == LOCK_IDX) begin
            rd_data[0] = lock_q;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (idx == 7'(p)) begin
                    rd_data[FW-1:0] = sel_q[p];
                end
            end
        end
    end

    // Writes are captured with the request and committed on the edge that
    // ends the ack cycle, so the new select drives the pads the cycle after ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
            pend_q      <= 1'b0;
            pend_idx_q  <= 7'd0;
            pend_val_q  <= '0;
            pend_bit0_q <= 1'b0;
            lock_q      <= 1'b0;
            for (int p = 0; p < NUM_PADS; p++) begin
                sel_q[p] <= '0;
            end
        end else begin
            ack_q       <= req;
            dat_q       <= (req && !wbs_we_i) ? rd_data : 32'd0;
            pend_q      <= req & wbs_we_i & wbs_sel_i[0];
            pend_idx_q  <= idx;
            pend_val_q  <= wbs_dat_i[FW-1:0];
            pend_bit0_q <= wbs_dat_i[0];
            if (pend_q) begin
                if (pend_idx_q == LOCK_IDX) begin
                    if (pend_bit0_q) begin
                        lock_q <= 1'b1;
                    end
                end else if (!lock_q) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        if (pend_idx_q == 7'(p)) begin
                            sel_q[p] <= pend_val_q;
                        end
                    end
                end
            end
        end
    end

    // Out-of-range selects are kept in the register but mux as GPIO.
    always_comb begin
        for (int p = 0; p < NUM_PADS; p++) begin
            eff[p] = (int'(sel_q[p]) < NUM_FUNCS) ? sel_q[p] : '0;
        end
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        if (!wb_rst_i) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                for (int f = 0; f < NUM_FUNCS; f++) begin
                    if (eff[p] == FW'(f)) begin
                        io_out[p] = func_out[f*NUM_PADS+p];
                        io_oeb[p] = ~func_oe[f*NUM_PADS+p];
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef PINMUX_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0]       deb_cnt [NUM_PADS];
    logic [NUM_PADS-1:0] deb_q;

    // The count runs only while the synchronised input disagrees with the
    // debounced level; the DEB_CYCLES-th consecutive disagreement flips it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            deb_q <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                deb_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (sync_q[SYNC_STAGES-1][p] != deb_q[p]) begin
                    if (deb_cnt[p] == CW'(DEB_CYCLES - 1)) begin
                        deb_q[p]   <= sync_q[SYNC_STAGES-1][p];
                        deb_cnt[p] <= '0;
                    end else begin
                        deb_cnt[p] <= deb_cnt[p] + 1'b1;
                    end
                end else begin
                    deb_cnt[p] <= '0;
                end
            end
        end
    end

    assign cond = deb_q;
`else
    assign cond = sync_q[SYNC_STAGES-1];
`endif

    // GPIO always sees the pad; an alternate sees it only when selected.
    always_comb begin
        func_in = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            func_in[p] = cond[p];
            for (int f = 1; f < NUM_FUNCS; f++) begin
                func_in[f*NUM_PADS+p] = cond[p] & (eff[p] == FW'(f));
            end
        end
    end

endmodule

// File: tb/tb_io_pinmux.sv
// tb/tb_io_pinmux.sv - scoreboard testbench for io_pinmux
module tb_io_pinmux;

    localparam int NP = 38;
    localparam int NF = 4;
    localparam int SS = 2;
    localparam int FW = $clog2(NF);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = 32'd0, dat_i = 32'd0;
    logic            ack;
    logic [31:0]     dat_o;
    logic [NP-1:0]   io_in = '0;
    logic [NP-1:0]   io_out, io_oeb;
    logic [NF*NP-1:0] func_out = '0, func_oe = '1, func_in;

    io_pinmux #(.NUM_PADS(NP), .NUM_FUNCS(NF), .SYNC_STAGES(SS), .DEB_CYCLES(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
        .func_out(func_out), .func_oe(func_oe), .func_in(func_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } txn_t;

    txn_t          sbq[$];
    logic [NP-1:0] hist[$];
    int            sel_m[NP];
    bit            lock_m;
    bit            rand_on = 1'b0;
    int            total = 0;
    int            bad = 0;

    logic [NP-1:0]    m_sync, m_out, m_oeb;
    logic [NF*NP-1:0] m_fin;
    txn_t             m_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NF*NP-1:0] rv();
        logic [NF*NP-1:0] v;
        for (int i = 0; i < NF*NP; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off = int'(a & 32'h1FC);
        if (off == 256) return {31'd0, lock_m};
        if (off < 4*NP) return 32'(sel_m[off/4]);
        return 32'd0;
    endfunction

    function automatic void model_write(input txn_t t);
        int off = int'(t.adr & 32'h1FC);
        if (!t.sel[0]) return;
        if (off == 256) begin
            if (t.dat[0]) lock_m = 1'b1;
        end else if (off < 4*NP && !lock_m) begin
            sel_m[off/4] = int'(t.dat % (1 << FW));
        end
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) sel_m[p] = 0;
        lock_m = 1'b0;
        sbq.delete();
    endfunction

    // Pad input history as the synchroniser sees it, newest first.
    always @(posedge clk or posedge rst) begin
        if (rst) hist.delete();
        else begin
            hist.push_front(io_in);
            if (hist.size() > 8) void'(hist.pop_back());
        end
    end

    // Monitor: pad mux checked every cycle; bus responses popped on ack.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("rst_io_oeb", io_oeb, {NP{1'b1}});
            chk("rst_io_out", io_out, '0);
            chk("rst_ack", ack, 0);
        end else begin
            m_sync = (hist.size() >= SS) ? hist[SS-1] : '0;
            m_fin = '0;
            for (int p = 0; p < NP; p++) begin
                int s;
                s = (sel_m[p] < NF) ? sel_m[p] : 0;
                m_out[p] = func_out[s*NP+p];
                m_oeb[p] = ~func_oe[s*NP+p];
                m_fin[p] = m_sync[p];
                if (s != 0) m_fin[s*NP+p] = m_sync[p];
            end
            chk("io_out", io_out, m_out);
            chk("io_oeb", io_oeb, m_oeb);
`ifndef PINMUX_DEBOUNCE_EN
            chk("func_in", func_in, m_fin);
`endif
            if (ack) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", ack, 0);
                end else begin
                    m_t = sbq.pop_front();
                    if (m_t.wr) model_write(m_t);
                    else chk("rdata", dat_o, m_t.exp);
                end
            end else begin
                chk("dat_idle", dat_o, 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (rand_on) begin
            func_out = rv();
            func_oe  = rv();
            io_in    = NP'(rv());
        end
    endtask

    task automatic wb(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
        txn_t t;
        int n;
        step();
        t.wr = wr; t.adr = a; t.dat = d; t.sel = s;
        t.exp = wr ? 32'd0 : model_read(a);
        sbq.push_back(t);
        stb = 1'b1; cyc = 1'b1; we = wr; adr = a; dat_i = d; sel = s;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack && n < 8);
        chk("ack_latency", n, 1);
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        step();
        chk("ack_single", ack, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   d;
        logic [NP-1:0] ev;
        model_reset();
        func_out = rv();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 chk("rst_oeb_all_ones", io_oeb, {NP{1'b1}});
        @(negedge clk) rst = 1'b0;
        step(); step();
        #1 ev = ~func_oe[NP-1:0];
        chk("post_rst_oeb", io_oeb, ev);

        for (int p = 0; p < NP; p++) begin
            wb(0, 32'(4*p), 0, 4'hF, d);
            if (p == 0 || p == NP-1) chk("sel_after_rst", d, 0);
        end

        wb(1, 32'h14, 32'h2, 4'hF, d);
        #1 chk("pad5_alt2", io_out[5], func_out[2*NP+5]);
        wb(0, 32'h14, 0, 4'hF, d);
        chk("sel5_read", d, 32'h2);

        wb(1, 32'hC, 32'h7, 4'hF, d);
        wb(1, 32'h1FC, 32'h5, 4'hF, d);
        wb(0, 32'hC, 0, 4'hF, d);
        chk("sel3_trunc", d, 32'h3);
        wb(0, 32'h1FC, 0, 4'hF, d);
        chk("unmapped_read", d, 0);

        rand_on = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int r, pad;
            logic [31:0] a;
            r   = $urandom_range(0, 9);
            pad = $urandom_range(0, NP + 4);
            a   = 32'(pad * 4) | 32'($urandom_range(0, 3)) | (32'($urandom) << 9);
            if (r == 0) wb(0, 32'h100, 0, 4'hF, d);
            else wb(bit'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), d);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_on = 1'b0;
        func_oe = '1;

        wb(1, 32'd40, 32'h1, 4'hF, d);
`ifndef PINMUX_DEBOUNCE_EN
        io_in[10] = 1'b0;
        repeat (3) step();
        io_in[10] = 1'b1;
        step();
        #1 chk("pad10_latency", func_in[10], 0);
        step();
        #1 chk("pad10_f0", func_in[10], 1);
        chk("pad10_f1", func_in[NP+10], 1);
        chk("pad10_f2", func_in[2*NP+10], 0);
`else
        begin
            bit seen;
            io_in = '0;
            repeat (40) step();
            io_in[8] = 1'b1;
            repeat (15) step();
            io_in[8] = 1'b0;
            seen = 1'b0;
            repeat (30) begin
                step();
                #1 if (func_in[8]) seen = 1'b1;
            end
            chk("deb_short_pulse", seen, 0);
            io_in[8] = 1'b1;
            repeat (30) step();
            #1 chk("deb_long_level", func_in[8], 1);
        end
`endif

        wb(1, 32'h100, 32'h1, 4'hF, d);
        wb(1, 32'h0, 32'h3, 4'hF, d);
        wb(0, 32'h0, 0, 4'hF, d);
        chk("sel0_locked", d, model_read(32'h0));
        wb(0, 32'h100, 0, 4'hF, d);
        chk("lock_read", d, 1);

        step();
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h10; dat_i = 32'h1; sel = 4'hF;
        #2 rst = 1'b1;
        model_reset();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        #1 chk("abort_no_ack", ack, 0);
        wb(0, 32'h100, 0, 4'hF, d);
        chk("lock_cleared", d, 0);
        wb(0, 32'h10, 0, 4'hF, d);
        chk("sel4_after_abort", d, 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
